// File: rtl/hdlc_bitstuff_tx.sv
// HDLC-style serial framer: flag-wrapped frames, zero insertion after five data 1s,
// and abort (eight 1s) on request or input underrun. One line bit per clock.
module hdlc_bitstuff_tx (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       abort,
  output logic       tx_bit,
  output logic       tx_flag,
  output logic       tx_stuff,
  output logic       busy
);

  typedef enum logic [1:0] {StFlag, StData, StAbort} state_e;

  localparam logic [7:0] FlagPat = 8'b0111_1110;

  state_e     r_state;
  logic [2:0] r_bitcnt;
  logic [2:0] r_ones;
  logic [7:0] r_shift;
  logic       r_last;
  logic       r_stuff;
  logic       r_tx_bit;
  logic       r_tx_flag;
  logic       r_tx_stuff;
  logic       r_busy;

  state_e     w_state_d;
  logic [2:0] w_bitcnt_d;
  logic [2:0] w_ones_d;
  logic [7:0] w_shift_d;
  logic       w_last_d;
  logic       w_stuff_d;
  logic       w_tx_bit_d;
  logic       w_tx_flag_d;
  logic       w_tx_stuff_d;
  logic       w_busy_d;

  logic       w_data_bit;
  logic [2:0] w_ones_inc;
  logic       w_stuff_req;
  logic       w_boundary;
  logic       w_accept;

  assign w_data_bit  = r_shift[0];
  assign w_ones_inc  = w_data_bit ? (r_ones + 3'd1) : 3'd0;
  // Current data bit is the fifth consecutive 1: a stuff 0 follows it.
  assign w_stuff_req = !r_stuff && w_data_bit && (r_ones == 3'd4);
  // Bit 7 closes the byte unless it triggers a stuff, in which case the stuff cycle does.
  assign w_boundary  = (r_bitcnt == 3'd7) && (r_stuff || !w_stuff_req);

  always_comb begin
    in_ready = 1'b0;
    unique case (r_state)
      StFlag:  in_ready = (r_bitcnt == 3'd7);
      StData:  in_ready = w_boundary && !r_last && !abort;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_d  = r_state;
    w_bitcnt_d = r_bitcnt;
    w_ones_d   = r_ones;
    w_shift_d  = r_shift;
    w_last_d   = r_last;
    w_stuff_d  = 1'b0;
    unique case (r_state)
      StFlag: begin
        w_ones_d   = 3'd0;
        w_bitcnt_d = r_bitcnt + 3'd1;
        if (w_accept) begin
          w_state_d = StData;
          w_shift_d = in_data;
          w_last_d  = in_last;
        end
      end
      StData: begin
        if (abort) begin
          w_state_d  = StAbort;
          w_bitcnt_d = 3'd0;
          w_ones_d   = 3'd0;
        end else if (w_stuff_req) begin
          // Hold bitcnt/shift; the stuff cycle performs the advance.
          w_stuff_d = 1'b1;
          w_ones_d  = 3'd0;
        end else begin
          w_ones_d = r_stuff ? 3'd0 : w_ones_inc;
          if (r_bitcnt == 3'd7) begin
            w_bitcnt_d = 3'd0;
            if (r_last) begin
              w_state_d = StFlag;
              w_ones_d  = 3'd0;
            end else if (in_valid) begin
              w_shift_d = in_data;
              w_last_d  = in_last;
            end else begin
              w_state_d = StAbort;
              w_ones_d  = 3'd0;
            end
          end else begin
            w_bitcnt_d = r_bitcnt + 3'd1;
            w_shift_d  = {1'b0, r_shift[7:1]};
          end
        end
      end
      StAbort: begin
        w_ones_d   = 3'd0;
        w_bitcnt_d = r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          w_state_d = StFlag;
        end
      end
      default: begin
        w_state_d  = StFlag;
        w_bitcnt_d = 3'd0;
        w_ones_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    w_tx_bit_d   = 1'b0;
    w_tx_flag_d  = 1'b0;
    w_tx_stuff_d = 1'b0;
    w_busy_d     = 1'b0;
    unique case (w_state_d)
      StFlag: begin
        w_tx_bit_d  = FlagPat[w_bitcnt_d];
        w_tx_flag_d = 1'b1;
      end
      StData: begin
        w_tx_bit_d   = w_stuff_d ? 1'b0 : w_shift_d[0];
        w_tx_stuff_d = w_stuff_d;
        w_busy_d     = 1'b1;
      end
      StAbort: begin
        w_tx_bit_d = 1'b1;
        w_busy_d   = 1'b1;
      end
      default: begin
        w_tx_flag_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StFlag;
      r_bitcnt   <= 3'd0;
      r_ones     <= 3'd0;
      r_shift    <= 8'd0;
      r_last     <= 1'b0;
      r_stuff    <= 1'b0;
      r_tx_bit   <= 1'b0;
      r_tx_flag  <= 1'b1;
      r_tx_stuff <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_bitcnt   <= w_bitcnt_d;
      r_ones     <= w_ones_d;
      r_shift    <= w_shift_d;
      r_last     <= w_last_d;
      r_stuff    <= w_stuff_d;
      r_tx_bit   <= w_tx_bit_d;
      r_tx_flag  <= w_tx_flag_d;
      r_tx_stuff <= w_tx_stuff_d;
      r_busy     <= w_busy_d;
    end
  end

  assign tx_bit   = r_tx_bit;
  assign tx_flag  = r_tx_flag;
  assign tx_stuff = r_tx_stuff;
  assign busy     = r_busy;

endmodule

// File: tb/tb_hdlc_bitstuff_tx.sv
// Directed bench for hdlc_bitstuff_tx: idle flags, stuffing, back-to-back bytes,
// underrun, abort and asynchronous reset, with hand-computed line sequences.
module tb_hdlc_bitstuff_tx;

  logic       clk;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       abort;
  logic       tx_bit;
  logic       tx_flag;
  logic       tx_stuff;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] flag_pat;

  hdlc_bitstuff_tx dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .abort    (abort),
    .tx_bit   (tx_bit),
    .tx_flag  (tx_flag),
    .tx_stuff (tx_stuff),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_out(input logic eb, input logic ef, input logic es, input logic ebusy,
                         input logic er, input string tag);
    #1;
    cmp({tag, ".tx_bit"},   tx_bit,   eb);
    cmp({tag, ".tx_flag"},  tx_flag,  ef);
    cmp({tag, ".tx_stuff"}, tx_stuff, es);
    cmp({tag, ".busy"},     busy,     ebusy);
    cmp({tag, ".in_ready"}, in_ready, er);
  endtask

  task automatic cycle(input logic eb, input logic ef, input logic es, input logic ebusy,
                       input logic er, input string tag);
    chk_out(eb, ef, es, ebusy, er, tag);
    @(negedge clk);
  endtask

  // Flag bits 0..6 (no handshake possible yet).
  task automatic flag_lead(input string tag);
    for (int i = 0; i < 7; i++) cycle(flag_pat[i], 1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Flag bit 7 with a byte offered and accepted.
  task automatic flag_accept(input logic [7:0] d, input logic last, input string tag);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic data_seq(input logic [31:0] bits, input logic [31:0] stuffs,
                          input logic [31:0] readys, input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(bits[i], 1'b0, stuffs[i], 1'b1, readys[i], tag);
  endtask

  task automatic abort_seq(input string tag);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    flag_pat = 8'b0111_1110;
    resetn   = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    abort    = 1'b0;
    repeat (2) @(negedge clk);
    chk_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
    resetn = 1'b1;

    // Idle: continuous flags, in_ready on every bitcnt 7.
    for (int i = 0; i < 40; i++)
      cycle(flag_pat[i % 8], 1'b1, 1'b0, 1'b0, (i % 8) == 7, "idle");

    // 0x3E, last: 0,1,1,1,1,1,stuff,0,0.
    flag_lead("f1");
    flag_accept(8'h3E, 1'b1, "f1_acc");
    in_valid = 1'b0;
    data_seq(32'h0000_003E, 32'h0000_0040, 32'h0, 9, "b3e");

    // 0xFF, last: 1x5,stuff,1,1,1 then a clean flag (ones must not carry over).
    flag_lead("f2");
    flag_accept(8'hFF, 1'b1, "f2_acc");
    in_valid = 1'b0;
    data_seq(32'h0000_01DF, 32'h0000_0020, 32'h0, 9, "bff");

    // 0xF8 then 0x07 (last), valid held high; in_ready moves to the stuff cycle.
    flag_lead("f3");
    flag_accept(8'hF8, 1'b0, "f3_acc");
    in_data = 8'h07;
    in_last = 1'b1;
    data_seq(32'h0000_0EF8, 32'h0000_0100, 32'h0000_0100, 17, "b2b");
    in_valid = 1'b0;

    // Underrun after 0xA5.
    flag_lead("f4");
    flag_accept(8'hA5, 1'b0, "f4_acc");
    in_valid = 1'b0;
    data_seq(32'h0000_00A5, 32'h0, 32'h0000_0080, 8, "ura5");
    abort_seq("urab");

    // Abort on bit 3 with valid held high.
    flag_lead("f5");
    flag_accept(8'h00, 1'b0, "f5_acc");
    data_seq(32'h0, 32'h0, 32'h0, 3, "ab_pre");
    abort = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ab_bit3");
    abort = 1'b0;
    abort_seq("ab_seq");

    // Abort on the boundary cycle must suppress in_ready.
    flag_lead("f6");
    flag_accept(8'h00, 1'b0, "f6_acc");
    data_seq(32'h0, 32'h0, 32'h0, 7, "abb_pre");
    abort = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "abb_bit7");
    abort    = 1'b0;
    in_valid = 1'b0;
    abort_seq("abb_seq");

    // Asynchronous reset mid-byte.
    flag_lead("f7");
    flag_accept(8'hFF, 1'b0, "f7_acc");
    in_valid = 1'b0;
    data_seq(32'h0000_0007, 32'h0, 32'h0, 3, "rst_pre");
    resetn = 1'b0;
    chk_out(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    flag_lead("rst_flag");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_flag7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
